// File: rtl/framebuffer.sv
// Double-buffered pixel framebuffer for a chained HUB75-style LED panel.
//
// Two independent banks of 32-bit pixel words. The write port stores one
// word per cycle with byte enables. The read port fetches the top-half pixel
// and the matching bottom-half pixel in the same cycle. It extracts one
// bit-plane of R/G/B from each and registers the six bits with one cycle of
// latency.
//
// Ports:
//   clk, rst_n              single rising-edge clock, async active-low reset
//   w_en, w_buffer, w_addr  write strobe, bank select, linear pixel index
//   w_strb, w_din           byte enables and pixel word
//   ctrl_n_rows/_n_cols     active panel geometry (sampled every cycle)
//   ctrl_bitdepth           bits per colour channel (sampled every cycle)
//   r_en, r_buffer, r_addr  read enable, bank select, top-half pixel index
//   r_bit                   bit-plane index
//   r_dout                  {Rt,Gt,Bt,Rb,Gb,Bb} of the selected bit-plane
module framebuffer #(
    parameter int unsigned N_ROWS_MAX     = 64,
    parameter int unsigned N_COLS_MAX     = 256,
    parameter int unsigned BITDEPTH_MAX   = 10,
    parameter int unsigned CTRL_REG_WIDTH = 32,
    localparam int unsigned WA            = $clog2(N_ROWS_MAX * N_COLS_MAX),
    localparam int unsigned RA            = WA - 1,
    localparam int unsigned BW            = $clog2(BITDEPTH_MAX)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_en,
    input  logic                      w_buffer,
    input  logic [WA-1:0]             w_addr,
    input  logic [3:0]                w_strb,
    input  logic [31:0]               w_din,
    input  logic [CTRL_REG_WIDTH-1:0] ctrl_n_rows,
    input  logic [CTRL_REG_WIDTH-1:0] ctrl_n_cols,
    input  logic [CTRL_REG_WIDTH-1:0] ctrl_bitdepth,
    input  logic                      r_en,
    input  logic                      r_buffer,
    input  logic [RA-1:0]             r_addr,
    input  logic [BW-1:0]             r_bit,
    output logic [5:0]                r_dout
);

    localparam int unsigned DEPTH = N_ROWS_MAX * N_COLS_MAX;
    // Wide enough that rows*cols and r_addr+half never wrap.
    localparam int unsigned PW    = 2 * CTRL_REG_WIDTH;
    // Wide enough for 2*bitdepth + r_bit without wrapping.
    localparam int unsigned XW    = CTRL_REG_WIDTH + 2;

    logic [31:0]   mem [2][DEPTH];

    logic [PW-1:0] n_pix;
    logic [PW-1:0] half;
    logic [PW-1:0] bot_addr;
    logic          wr_ok;
    logic          bot_ok;
    logic          bit_ok;
    logic [WA-1:0] top_idx;
    logic [WA-1:0] bot_idx;
    logic [31:0]   top_word;
    logic [31:0]   bot_word;
    logic [XW-1:0] idx_b;
    logic [XW-1:0] idx_g;
    logic [XW-1:0] idx_r;
    logic [5:0]    r_dout_d;
    logic [5:0]    r_dout_q;

    // Bit selects beyond the 32-bit word (large ctrl_bitdepth) read as 0.
    function automatic logic pick(input logic [31:0] word, input logic [XW-1:0] idx);
        return (idx < XW'(32)) ? word[idx[4:0]] : 1'b0;
    endfunction

    // Write qualification: writes outside the active panel area are dropped,
    // and nothing is written while reset is held.
    always_comb begin
        n_pix = PW'(ctrl_n_rows) * PW'(ctrl_n_cols);
        wr_ok = rst_n && w_en
                && (PW'(w_addr) < n_pix)
                && (PW'(w_addr) < PW'(DEPTH));
    end

    // Storage has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (w_strb[k]) begin
                    mem[w_buffer][w_addr][8*k +: 8] <= w_din[8*k +: 8];
                end
            end
        end
    end

    // Read path: the bottom pixel sits half a panel further on. The array is
    // read before the write edge lands, so a same-cycle write returns old data.
    always_comb begin
        half     = PW'(ctrl_n_rows >> 1) * PW'(ctrl_n_cols);
        top_idx  = WA'(r_addr);
        bot_addr = PW'(r_addr) + half;
        bot_ok   = bot_addr < PW'(DEPTH);
        bot_idx  = WA'(bot_addr);
        top_word = mem[r_buffer][top_idx];
        bot_word = bot_ok ? mem[r_buffer][bot_idx] : 32'h0;

        idx_b    = XW'(r_bit);
        idx_g    = idx_b + XW'(ctrl_bitdepth);
        idx_r    = idx_g + XW'(ctrl_bitdepth);
        bit_ok   = (idx_b < XW'(ctrl_bitdepth)) && (32'(r_bit) < BITDEPTH_MAX);

        r_dout_d = 6'b0;
        if (bit_ok) begin
            r_dout_d = {pick(top_word, idx_r), pick(top_word, idx_g), pick(top_word, idx_b),
                        pick(bot_word, idx_r), pick(bot_word, idx_g), pick(bot_word, idx_b)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_q <= 6'b0;
        end else if (r_en) begin
            r_dout_q <= r_dout_d;
        end
    end

    assign r_dout = r_dout_q;

endmodule

// File: tb/tb_framebuffer.sv
// Directed self-checking bench for framebuffer.
module tb_framebuffer;

    logic        clk;
    logic        rst_n;
    logic        w_en;
    logic        w_buffer;
    logic [13:0] w_addr;
    logic [3:0]  w_strb;
    logic [31:0] w_din;
    logic [31:0] ctrl_n_rows;
    logic [31:0] ctrl_n_cols;
    logic [31:0] ctrl_bitdepth;
    logic        r_en;
    logic        r_buffer;
    logic [12:0] r_addr;
    logic [3:0]  r_bit;
    logic [5:0]  r_dout;

    int total;
    int bad;

    framebuffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .w_en          (w_en),
        .w_buffer      (w_buffer),
        .w_addr        (w_addr),
        .w_strb        (w_strb),
        .w_din         (w_din),
        .ctrl_n_rows   (ctrl_n_rows),
        .ctrl_n_cols   (ctrl_n_cols),
        .ctrl_bitdepth (ctrl_bitdepth),
        .r_en          (r_en),
        .r_buffer      (r_buffer),
        .r_addr        (r_addr),
        .r_bit         (r_bit),
        .r_dout        (r_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write at a negedge; returns at the following negedge.
    task automatic wr(input logic bank, input logic [13:0] addr, input logic [3:0] strb,
                      input logic [31:0] din);
        w_en     = 1'b1;
        w_buffer = bank;
        w_addr   = addr;
        w_strb   = strb;
        w_din    = din;
        @(posedge clk);
        @(negedge clk);
        w_en     = 1'b0;
    endtask

    // One read cycle; leaves r_en high so calls run back to back.
    task automatic rd(input logic bank, input logic [12:0] addr, input logic [3:0] pl,
                      output logic [5:0] d);
        r_en     = 1'b1;
        r_buffer = bank;
        r_addr   = addr;
        r_bit    = pl;
        @(posedge clk);
        @(negedge clk);
        d = r_dout;
    endtask

    // Reassemble 8-bit-per-channel top and bottom pixels from 8 bit-planes.
    task automatic rd_pixel(input logic bank, input logic [12:0] addr,
                            output logic [23:0] top, output logic [23:0] bot);
        logic [5:0] d;
        top = '0;
        bot = '0;
        for (int b = 0; b < 8; b++) begin
            rd(bank, addr, 4'(b), d);
            top[16+b] = d[5];
            top[8+b]  = d[4];
            top[b]    = d[3];
            bot[16+b] = d[2];
            bot[8+b]  = d[1];
            bot[b]    = d[0];
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        r_en  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (r_dout !== 6'b0) begin
            bad++;
            $display("FAIL reset_dout: got %b want %b", r_dout, 6'b0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [23:0] t, b;
        wr(1'b0, 14'd0,    4'hF, 32'h00AAFF11);
        wr(1'b0, 14'd2048, 4'hF, 32'h00AAFF11);
        rd_pixel(1'b0, 13'd0, t, b);
        total++;
        if (t !== 24'hAAFF11) begin
            bad++;
            $display("FAIL basic_top: got %h want %h", t, 24'hAAFF11);
        end
        total++;
        if (b !== 24'hAAFF11) begin
            bad++;
            $display("FAIL basic_bot: got %h want %h", b, 24'hAAFF11);
        end
    endtask

    task automatic test_banks;
        logic [23:0] t, b;
        wr(1'b1, 14'd0,    4'hF, 32'h00FF0022);
        wr(1'b1, 14'd2048, 4'hF, 32'h00FF0022);
        rd_pixel(1'b0, 13'd0, t, b);
        total++;
        if (t !== 24'hAAFF11 || b !== 24'hAAFF11) begin
            bad++;
            $display("FAIL bank0_kept: got %h/%h want %h/%h", t, b, 24'hAAFF11, 24'hAAFF11);
        end
        rd_pixel(1'b1, 13'd0, t, b);
        total++;
        if (t !== 24'hFF0022 || b !== 24'hFF0022) begin
            bad++;
            $display("FAIL bank1_read: got %h/%h want %h/%h", t, b, 24'hFF0022, 24'hFF0022);
        end
    endtask

    // Alternating addresses and planes every cycle.
    task automatic test_bit_planes;
        logic [5:0] d;
        logic [5:0] exp1;
        wr(1'b0, 14'd0,    4'hF, 32'h00FFFFFF);
        wr(1'b0, 14'd2048, 4'hF, 32'h00FFFFFF);
        wr(1'b0, 14'd1,    4'hF, 32'h00AAAAAA);
        wr(1'b0, 14'd2049, 4'hF, 32'h00AAAAAA);
        for (int b = 0; b < 8; b++) begin
            rd(1'b0, 13'd0, 4'(b), d);
            total++;
            if (d !== 6'b111111) begin
                bad++;
                $display("FAIL planes_addr0 bit %0d: got %b want %b", b, d, 6'b111111);
            end
            exp1 = (b % 2 == 1) ? 6'b111111 : 6'b000000;
            rd(1'b0, 13'd1, 4'(b), d);
            total++;
            if (d !== exp1) begin
                bad++;
                $display("FAIL planes_addr1 bit %0d: got %b want %b", b, d, exp1);
            end
        end
    endtask

    task automatic test_strobe;
        logic [23:0] t, b;
        wr(1'b0, 14'd0, 4'hF, 32'h00AAFF11);
        wr(1'b0, 14'd0, 4'b0001, 32'h00000000);
        rd_pixel(1'b0, 13'd0, t, b);
        total++;
        if (t !== 24'hAAFF00) begin
            bad++;
            $display("FAIL strobe_byte0: got %h want %h", t, 24'hAAFF00);
        end
        total++;
        if (b !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL strobe_bot: got %h want %h", b, 24'hFFFFFF);
        end
        // Byte 3 is above 3*bitdepth and must not show up in the pixel.
        wr(1'b0, 14'd0, 4'b1000, 32'hFF000000);
        rd_pixel(1'b0, 13'd0, t, b);
        total++;
        if (t !== 24'hAAFF00) begin
            bad++;
            $display("FAIL strobe_byte3: got %h want %h", t, 24'hAAFF00);
        end
    endtask

    task automatic test_addr_bounds;
        logic [23:0] t, b;
        ctrl_n_rows = 32'd128;
        wr(1'b0, 14'd4096, 4'hF, 32'h00123456);
        ctrl_n_rows = 32'd64;
        wr(1'b0, 14'd4096, 4'hF, 32'h00ABCDEF);
        wr(1'b0, 14'd4095, 4'hF, 32'h00C0FFEE);
        ctrl_n_rows = 32'd128;
        rd_pixel(1'b0, 13'd0, t, b);
        total++;
        if (b !== 24'h123456) begin
            bad++;
            $display("FAIL write_ignored: got %h want %h", b, 24'h123456);
        end
        total++;
        if (t !== 24'hAAFF00) begin
            bad++;
            $display("FAIL half128_top: got %h want %h", t, 24'hAAFF00);
        end
        ctrl_n_rows = 32'd64;
        rd_pixel(1'b0, 13'd2047, t, b);
        total++;
        if (b !== 24'hC0FFEE) begin
            bad++;
            $display("FAIL last_addr: got %h want %h", b, 24'hC0FFEE);
        end
    endtask

    task automatic test_bottom_oob;
        logic [5:0] d;
        ctrl_n_rows = 32'd128;
        ctrl_n_cols = 32'd256;
        rd(1'b0, 13'd0, 4'd1, d);
        total++;
        if (d !== 6'b110000) begin
            bad++;
            $display("FAIL bottom_oob: got %b want %b", d, 6'b110000);
        end
        ctrl_n_rows = 32'd64;
        ctrl_n_cols = 32'd64;
    endtask

    task automatic test_bitdepth;
        logic [5:0] d;
        logic [3:0] pl  [7];
        logic [31:0] bd [7];
        logic [5:0] exp [7];
        // top word 0xFFAAFF00, bottom word 0x00FFFFFF
        pl[0] = 4'd7;  bd[0] = 32'd8;  exp[0] = 6'b110111;
        pl[1] = 4'd8;  bd[1] = 32'd8;  exp[1] = 6'b000000;
        pl[2] = 4'd0;  bd[2] = 32'd4;  exp[2] = 6'b100111;
        pl[3] = 4'd3;  bd[3] = 32'd4;  exp[3] = 6'b100111;
        pl[4] = 4'd4;  bd[4] = 32'd4;  exp[4] = 6'b000000;
        pl[5] = 4'd9;  bd[5] = 32'd12; exp[5] = 6'b011011;
        pl[6] = 4'd10; bd[6] = 32'd12; exp[6] = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            ctrl_bitdepth = bd[i];
            rd(1'b0, 13'd0, pl[i], d);
            total++;
            if (d !== exp[i]) begin
                bad++;
                $display("FAIL bitdepth bd=%0d bit=%0d: got %b want %b", bd[i], pl[i], d, exp[i]);
            end
        end
        ctrl_bitdepth = 32'd8;
    endtask

    task automatic test_read_first;
        logic [5:0] d;
        w_en     = 1'b1;
        w_buffer = 1'b0;
        w_addr   = 14'd1;
        w_strb   = 4'hF;
        w_din    = 32'h00555555;
        r_en     = 1'b1;
        r_buffer = 1'b0;
        r_addr   = 13'd1;
        r_bit    = 4'd1;
        @(posedge clk);
        @(negedge clk);
        w_en = 1'b0;
        total++;
        if (r_dout !== 6'b111111) begin
            bad++;
            $display("FAIL read_first_old: got %b want %b", r_dout, 6'b111111);
        end
        rd(1'b0, 13'd1, 4'd1, d);
        total++;
        if (d !== 6'b000111) begin
            bad++;
            $display("FAIL read_first_new: got %b want %b", d, 6'b000111);
        end
    endtask

    task automatic test_hold;
        logic [5:0] d;
        rd(1'b0, 13'd0, 4'd7, d);
        total++;
        if (d !== 6'b110111) begin
            bad++;
            $display("FAIL hold_setup: got %b want %b", d, 6'b110111);
        end
        r_en   = 1'b0;
        r_addr = 13'd1;
        r_bit  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (r_dout !== 6'b110111) begin
            bad++;
            $display("FAIL hold: got %b want %b", r_dout, 6'b110111);
        end
    endtask

    task automatic test_reset_mid_read;
        logic [5:0] d;
        logic [23:0] t, b;
        rd(1'b0, 13'd0, 4'd7, d);
        total++;
        if (d !== 6'b110111) begin
            bad++;
            $display("FAIL mid_reset_setup: got %b want %b", d, 6'b110111);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (r_dout !== 6'b0) begin
            bad++;
            $display("FAIL async_reset: got %b want %b", r_dout, 6'b0);
        end
        // Write attempt while reset is held must be dropped.
        w_en     = 1'b1;
        w_buffer = 1'b0;
        w_addr   = 14'd0;
        w_strb   = 4'hF;
        w_din    = 32'h00000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (r_dout !== 6'b0) begin
            bad++;
            $display("FAIL reset_hold: got %b want %b", r_dout, 6'b0);
        end
        w_en  = 1'b0;
        rst_n = 1'b1;
        rd(1'b0, 13'd0, 4'd7, d);
        total++;
        if (d !== 6'b110111) begin
            bad++;
            $display("FAIL after_reset: got %b want %b", d, 6'b110111);
        end
        rd_pixel(1'b0, 13'd0, t, b);
        total++;
        if (t !== 24'hAAFF00) begin
            bad++;
            $display("FAIL data_survives: got %h want %h", t, 24'hAAFF00);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        w_en          = 1'b0;
        w_buffer      = 1'b0;
        w_addr        = '0;
        w_strb        = '0;
        w_din         = '0;
        r_en          = 1'b0;
        r_buffer      = 1'b0;
        r_addr        = '0;
        r_bit         = '0;
        ctrl_n_rows   = 32'd64;
        ctrl_n_cols   = 32'd64;
        ctrl_bitdepth = 32'd8;

        test_reset;
        test_basic;
        test_banks;
        test_bit_planes;
        test_strobe;
        test_addr_bounds;
        test_bottom_oob;
        test_bitdepth;
        test_read_first;
        test_hold;
        test_reset_mid_read;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
